apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_addr_decoder.sv | 30 +++
 rtl/apb_master_bridge.sv | 179 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared state encoding and constants for the APB master bridge and its address decoder.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_e;

   localparam logic [31:0] APB_BASE_ADDR     = 32'h1000_0000;
   localparam int          SLAVE_WINDOW_BITS = 12;
   localparam logic [31:0] TIMEOUT_RDATA     = 32'hDEAD_BEEF;

   // A lone slave still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB region decoder: page address -> hit flag, slave index and one-hot select.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter logic [31:0] BASE_ADDR  = APB_BASE_ADDR,
   localparam int         IDX_W      = idx_width(NUM_SLAVES)
)(
   input  logic [31:SLAVE_WINDOW_BITS] page,
   output logic                        hit,
   output logic [IDX_W-1:0]            index,
   output logic [NUM_SLAVES-1:0]       sel
);

   localparam int         REGION_LSB  = SLAVE_WINDOW_BITS + 4;
   localparam logic [4:0] SLAVE_COUNT = 5'(NUM_SLAVES);

   logic [3:0] slot_s;
   logic       region_hit_s;

   assign slot_s       = page[REGION_LSB-1:SLAVE_WINDOW_BITS];
   assign region_hit_s = (page[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB]);
   assign hit          = region_hit_s && ({1'b0, slot_s} < SLAVE_COUNT);
   assign index        = slot_s[IDX_W-1:0];

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_sel
      assign sel[g] = hit && (slot_s == 4'(g));
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-beat CPU load/store to APB3 master bridge with one-hot slave select.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter logic [31:0] BASE_ADDR  = APB_BASE_ADDR
`ifdef APB_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYCLES = 16
`endif
)(
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic                       transfer,
   input  logic                       write,
   input  logic [31:0]                addr,
   input  logic [31:0]                wdata,
   output logic [31:0]                rdata,
   output logic                       ready,
   output logic                       err,
   output logic [31:0]                PADDR,
   output logic [31:0]                PWDATA,
   output logic                       PWRITE,
   output logic                       PENABLE,
   output logic [NUM_SLAVES-1:0]      PSEL,
   input  logic [NUM_SLAVES*32-1:0]   PRDATA,
   input  logic [NUM_SLAVES-1:0]      PREADY
);

   localparam int IDX_W = idx_width(NUM_SLAVES);

   apb_state_e              state_r, state_nxt_s;
   logic [IDX_W-1:0]        idx_r, idx_nxt_s;
   logic                    dec_hit_s;
   logic [IDX_W-1:0]        dec_idx_s;
   logic [NUM_SLAVES-1:0]   dec_sel_s;
   logic [31:0]             prdata_arr_s [NUM_SLAVES];
   logic [31:0]             prdata_sel_s;
   logic                    pready_sel_s;

   logic [31:0]             paddr_nxt_s, pwdata_nxt_s, rdata_nxt_s;
   logic                    pwrite_nxt_s, penable_nxt_s, ready_nxt_s, err_nxt_s;
   logic [NUM_SLAVES-1:0]   psel_nxt_s;

`ifdef APB_TIMEOUT_EN
   localparam int             TO_W     = (idx_width(TIMEOUT_CYCLES + 1) > 5) ?
                                         idx_width(TIMEOUT_CYCLES + 1) : 5;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
   logic [TO_W-1:0]           to_cnt_r, to_cnt_nxt_s, to_cnt_inc_s;
   assign to_cnt_inc_s = to_cnt_r + TO_ONE;
`endif

   apb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .BASE_ADDR  (BASE_ADDR)
   ) u_decoder (
      .page  (addr[31:SLAVE_WINDOW_BITS]),
      .hit   (dec_hit_s),
      .index (dec_idx_s),
      .sel   (dec_sel_s)
   );

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_prdata
      assign prdata_arr_s[g] = PRDATA[g*32 +: 32];
   end

   // Only the slave latched at request time may complete or return data.
   assign prdata_sel_s = prdata_arr_s[idx_r];
   assign pready_sel_s = PREADY[idx_r];

   // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequence.
   always_comb begin
      state_nxt_s   = state_r;
      idx_nxt_s     = idx_r;
      paddr_nxt_s   = PADDR;
      pwdata_nxt_s  = PWDATA;
      pwrite_nxt_s  = PWRITE;
      psel_nxt_s    = PSEL;
      penable_nxt_s = PENABLE;
      rdata_nxt_s   = rdata;
      ready_nxt_s   = 1'b0;
      err_nxt_s     = 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt_nxt_s  = to_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (transfer) begin
               paddr_nxt_s  = addr;
               pwdata_nxt_s = wdata;
               pwrite_nxt_s = write;
               if (dec_hit_s) begin
                  state_nxt_s = SETUP;
                  idx_nxt_s   = dec_idx_s;
                  psel_nxt_s  = dec_sel_s;
               end else begin
                  ready_nxt_s = 1'b1;
                  err_nxt_s   = 1'b1;
                  rdata_nxt_s = 32'h0000_0000;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SETUP: begin
            state_nxt_s   = ACCESS;
            penable_nxt_s = 1'b1;
`ifdef APB_TIMEOUT_EN
            to_cnt_nxt_s  = {TO_W{1'b0}};
`endif
         end
         ACCESS: begin
            if (pready_sel_s) begin
               state_nxt_s   = IDLE;
               psel_nxt_s    = {NUM_SLAVES{1'b0}};
               penable_nxt_s = 1'b0;
               ready_nxt_s   = 1'b1;
               rdata_nxt_s   = PWRITE ? rdata : prdata_sel_s;
            end else begin
`ifdef APB_TIMEOUT_EN
               if (to_cnt_inc_s == TO_LIMIT) begin
                  state_nxt_s   = IDLE;
                  psel_nxt_s    = {NUM_SLAVES{1'b0}};
                  penable_nxt_s = 1'b0;
                  ready_nxt_s   = 1'b1;
                  err_nxt_s     = 1'b1;
                  rdata_nxt_s   = TIMEOUT_RDATA;
               end else begin
                  to_cnt_nxt_s  = to_cnt_inc_s;
               end
`else
               state_nxt_s = ACCESS;
`endif
            end
         end
         default: begin
            state_nxt_s   = IDLE;
            psel_nxt_s    = {NUM_SLAVES{1'b0}};
            penable_nxt_s = 1'b0;
         end
      endcase
   end

   // State and registered bus/CPU outputs; reset aborts any transfer without a ready pulse.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r <= IDLE;
         idx_r   <= {IDX_W{1'b0}};
         PADDR   <= 32'h0000_0000;
         PWDATA  <= 32'h0000_0000;
         PWRITE  <= 1'b0;
         PSEL    <= {NUM_SLAVES{1'b0}};
         PENABLE <= 1'b0;
         rdata   <= 32'h0000_0000;
         ready   <= 1'b0;
         err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
         to_cnt_r <= {TO_W{1'b0}};
`endif
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
         PADDR   <= paddr_nxt_s;
         PWDATA  <= pwdata_nxt_s;
         PWRITE  <= pwrite_nxt_s;
         PSEL    <= psel_nxt_s;
         PENABLE <= penable_nxt_s;
         rdata   <= rdata_nxt_s;
         ready   <= ready_nxt_s;
         err     <= err_nxt_s;
`ifdef APB_TIMEOUT_EN
         to_cnt_r <= to_cnt_nxt_s;
`endif
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge with behavioural APB slaves.
module tb_apb_master_bridge;

   localparam int          NS   = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              transfer, write;
   logic [31:0]       addr, wdata;
   logic [31:0]       rdata;
   logic              ready, err;
   logic [31:0]       PADDR, PWDATA;
   logic              PWRITE, PENABLE;
   logic [NS-1:0]     PSEL;
   logic [NS*32-1:0]  PRDATA;
   logic [NS-1:0]     PREADY;

   apb_master_bridge #(.NUM_SLAVES(NS), .BASE_ADDR(BASE)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
      .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural slaves ----------------
   int          wait_cfg [NS];
   int          acc_cnt  [NS];
   logic [31:0] smem     [NS][16];
   logic [31:0] noise_rd [NS];
   logic [NS-1:0] noise_rdy;

   always @(negedge PCLK) begin
      noise_rdy <= NS'($urandom);
      for (int i = 0; i < NS; i++) noise_rd[i] <= $urandom;
   end

   always_comb begin
      PREADY = '0;
      PRDATA = '0;
      for (int i = 0; i < NS; i++) begin
         PREADY[i] = (PSEL[i] && PENABLE) ? (acc_cnt[i] >= wait_cfg[i]) : noise_rdy[i];
         PRDATA[i*32 +: 32] = PSEL[i] ? smem[i][PADDR[5:2]] : noise_rd[i];
      end
   end

   always @(posedge PCLK) begin
      for (int i = 0; i < NS; i++) begin
         if (PRESET) begin
            acc_cnt[i] <= 0;
            for (int j = 0; j < 16; j++) smem[i][j] <= 32'h0;
         end else begin
            if (PSEL[i] && PENABLE && !PREADY[i]) acc_cnt[i] <= acc_cnt[i] + 1;
            else acc_cnt[i] <= 0;
            if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) smem[i][PADDR[5:2]] <= PWDATA;
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          t0;
   } exp_t;

   exp_t        q[$];
   logic [31:0] ref_mem [logic [15:0]];
   logic [31:0] model_rdata = 32'h0;
   int          sel_cyc = 0;

   task automatic issue_only(input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      logic hit, to_s;
      int   s, wt;
      hit = (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(NS) * 33'h1000));
      e.wr = w; e.addr = a; e.wdata = d; e.t0 = cyc; e.err = 1'b0; e.sel = 4'h0;
      if (!hit) begin
         model_rdata = 32'h0;
         e.err = 1'b1;
         e.lat = 1;
      end else begin
         s     = int'((a - BASE) / 32'h1000);
         wt    = wait_cfg[s];
         e.sel = 4'(1 << s);
         to_s  = 1'b0;
`ifdef APB_TIMEOUT_EN
         to_s  = (wt >= 16);
`endif
         if (to_s) begin
            model_rdata = 32'hDEAD_BEEF;
            e.err = 1'b1;
            e.lat = 3 + 15;
         end else begin
            e.lat = 3 + wt;
            if (w) ref_mem[a[15:0]] = d;
            else model_rdata = ref_mem.exists(a[15:0]) ? ref_mem[a[15:0]] : 32'h0;
         end
      end
      e.rdata = model_rdata;
      q.push_back(e);
      transfer = 1'b1; write = w; addr = a; wdata = d;
   endtask

   // Issue, then wait for ready while throwing ignored requests at the busy bridge.
   task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
      issue_only(w, a, d);
      for (int k = 0; k < 100; k++) begin
         @(negedge PCLK);
         if (ready) return;
         transfer = 1'($urandom_range(0, 1));
         write    = 1'($urandom_range(0, 1));
         addr     = $urandom;
         wdata    = $urandom;
      end
      chk("ready_timeout", 32'(ready), 32'h1);
   endtask

   task automatic idle(input int n);
      transfer = 1'b0;
      addr     = $urandom;
      repeat (n) @(negedge PCLK);
   endtask

   always @(negedge PCLK) begin
      exp_t e;
      if (PRESET) begin
         sel_cyc <= 0;
      end else begin
         if (PSEL != '0) begin
            if (q.size() == 0) begin
               chk("psel_unexpected", 32'(PSEL), 32'h0);
            end else begin
               chk("psel", 32'(PSEL), 32'(q[0].sel));
               chk("paddr", PADDR, q[0].addr);
               chk("pwrite", 32'(PWRITE), 32'(q[0].wr));
               if (q[0].wr) chk("pwdata", PWDATA, q[0].wdata);
               chk("penable_phase", 32'(PENABLE), (sel_cyc == 0) ? 32'h0 : 32'h1);
            end
            sel_cyc <= sel_cyc + 1;
         end else begin
            chk("penable_no_psel", 32'(PENABLE), 32'h0);
         end
         if (ready) begin
            if (q.size() == 0) begin
               chk("spurious_ready", 32'(ready), 32'h0);
            end else begin
               e = q.pop_front();
               chk("rdata", rdata, e.rdata);
               chk("err", 32'(err), 32'(e.err));
               chk("latency", 32'(cyc - e.t0), 32'(e.lat));
               chk("psel_at_ready", 32'(PSEL), 32'h0);
            end
            sel_cyc <= 0;
         end else begin
            chk("err_without_ready", 32'(err), 32'h0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0;
      wait_cfg[0] = 0; wait_cfg[1] = 0; wait_cfg[2] = 1; wait_cfg[3] = 0;
      repeat (3) @(negedge PCLK);
      chk("rst_psel", 32'(PSEL), 32'h0);
      chk("rst_penable", 32'(PENABLE), 32'h0);
      chk("rst_pwrite", 32'(PWRITE), 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      PRESET = 1'b0;
      idle(2);

      // directed: registered-ready GPIO slave, misses, long wait, back-to-back
      do_xfer(1'b1, 32'h1000_2000, 32'h0000_00FF);
      do_xfer(1'b1, 32'h1000_2004, 32'h0000_00A5);
      do_xfer(1'b0, 32'h1000_2004, 32'h0);
      do_xfer(1'b0, 32'h1000_2000, 32'h0);
      do_xfer(1'b0, 32'h2000_0000, 32'h0);
      do_xfer(1'b1, 32'h1000_5000, 32'h1234_5678);
      idle(1);
      wait_cfg[1] = 5;
      do_xfer(1'b1, 32'h1000_1000, 32'hCAFE_F00D);
      do_xfer(1'b0, 32'h1000_1000, 32'h0);
      wait_cfg[1] = 0;
      idle(2);

      // randomized traffic
      for (int n = 0; n < 120; n++) begin
         wait_cfg[1] = $urandom_range(0, 5);
         if ($urandom_range(0, 9) < 2) begin
            case ($urandom_range(0, 2))
               0:       a = BASE + 32'($urandom_range(4, 15)) * 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
               1:       a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
               default: a = $urandom & 32'h0FFF_FFFC;
            endcase
         end else begin
            a = BASE + 32'($urandom_range(0, NS - 1)) * 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
         end
         do_xfer(1'($urandom_range(0, 1)), a, $urandom);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);

`ifdef APB_TIMEOUT_EN
      wait_cfg[3] = 255;
      do_xfer(1'b0, 32'h1000_300C, 32'h0);
      wait_cfg[3] = 0;
      do_xfer(1'b0, 32'h1000_0000, 32'h0);
      idle(2);
`endif

      // reset in the middle of ACCESS, then recover
      wait_cfg[1] = 20;
      issue_only(1'b0, 32'h1000_1008, 32'h0);
      repeat (5) begin
         @(negedge PCLK);
         transfer = 1'b0;
      end
      PRESET = 1'b1;
      q.delete();
      ref_mem.delete();
      model_rdata = 32'h0;
      @(negedge PCLK);
      chk("abort_psel", 32'(PSEL), 32'h0);
      chk("abort_penable", 32'(PENABLE), 32'h0);
      chk("abort_ready", 32'(ready), 32'h0);
      chk("abort_rdata", rdata, 32'h0);
      PRESET = 1'b0;
      wait_cfg[1] = 0;
      idle(4);
      do_xfer(1'b1, 32'h1000_1008, 32'h5A5A_0001);
      do_xfer(1'b0, 32'h1000_1008, 32'h0);
      idle(5);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
